pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage ARM core. It detects RAW data hazards and generates the `hazard` signal consumed by the ID stage. It sequences branch flushes and runs a wait-state FSM that stalls the whole pipeline while a load or store holds the multicycle SRAM. It also keeps saturating stall and flush counters for bring-up.

## Interface
Parameters:
- `SRAM_WAIT`, default 5: SRAM busy cycles per access, range 1..15.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_src1`  in  4  Rn index of the instruction in ID.
- `id_src2`  in  4  Rm/Rd index of the instruction in ID.
- `id_two_src`  in  1  ID instruction reads `id_src2`.
- `exe_dest`  in  4  destination register of the EXE-stage instruction.
- `exe_wb_en`  in  1  EXE-stage instruction writes `exe_dest`.
- `exe_mem_r_en`  in  1  EXE-stage instruction is a load.
- `mem_dest`  in  4  destination register of the MEM-stage instruction.
- `mem_wb_en`  in  1  MEM-stage instruction writes `mem_dest`.
- `fwd_en`  in  1  forwarding unit is active.
- `exe_branch_taken`  in  1  branch resolved taken in EXE.
- `mem_r_en`  in  1  MEM-stage load.
- `mem_w_en`  in  1  MEM-stage store.
- `hazard`  out  1  data hazard; goes to the ID stage.
- `freeze_pc`  out  1  hold the PC.
- `freeze_if_id`  out  1  hold the IF/ID register.
- `flush_if_id`  out  1  clear the IF/ID register to a NOP.
- `flush_id_exe`  out  1  insert a bubble in the ID/EXE register.
- `mem_stall`  out  1  freeze every pipeline register: PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- `sram_en`  out  1  SRAM access strobe.
- `sram_we`  out  1  SRAM write strobe.
- `stall_cnt`  out  `CNT_W`  cycles with `mem_stall` or `hazard` asserted.
- `flush_cnt`  out  `CNT_W`  taken-branch flush events.

## Operation
Hazard detection (combinational):
- `m1` = `exe_wb_en` & (`exe_dest` == `id_src1`). `m2` = `exe_wb_en` & `id_two_src` & (`exe_dest` == `id_src2`).
- `n1`, `n2`: same as `m1`, `m2`, using `mem_dest` and `mem_wb_en`.
- When `fwd_en` = 0: `hazard` = `m1` | `m2` | `n1` | `n2`.
- When `fwd_en` = 1: `hazard` = (`m1` | `m2`) & `exe_mem_r_en`. This is load-use only.

Priority when events coincide:
- `mem_stall` beats branch, and branch beats hazard.
- While `mem_stall` = 1: all flush and freeze outputs other than `mem_stall` are 0, and `hazard` is still reported.
- A taken branch therefore waits in the frozen EXE stage and flushes on the first non-stalled cycle.
- Branch, no stall: `flush_if_id` = `flush_id_exe` = 1 and both freezes = 0. A simultaneous hazard is discarded because its instruction is flushed.
- Hazard only: `freeze_pc` = `freeze_if_id` = `flush_id_exe` = 1.

Memory FSM states: IDLE, BUSY, DONE.
- IDLE with `mem_r_en`|`mem_w_en`: `mem_stall` = 1, `sram_en` = 1, `sram_we` = `mem_w_en`. Load `cnt` = `SRAM_WAIT`-1 and go to BUSY.
- BUSY: `mem_stall` = 1 and strobes held. Decrement `cnt`; when `cnt` == 0, go to DONE.
- DONE: `mem_stall` = 0 and strobes low, so the instruction advances. Always return to IDLE. This state prevents the same instruction from re-triggering.
- Back-to-back memory instructions: the next request is seen in IDLE on the following cycle.

Counters:
- Each counter increments by 1 per qualifying cycle or event and saturates at all-ones.

## Timing
- A memory instruction stalls the pipeline `SRAM_WAIT`+1 cycles and occupies MEM for `SRAM_WAIT`+2 cycles.
- Hazard and flush outputs are combinational in the same cycle, with no added latency.
- The FSM and counters are registered.
- Reset:
  - State = IDLE, `cnt` = 0, both counters = 0.
  - While `rst` = 1, every output is forced to 0.
- Reset during BUSY: state is IDLE on the next edge, and `mem_stall` is 0 in the first cycle after `rst` falls unless a new request is present.
- Register index 15 is compared like any other index; no special-casing.

## Structure
- Package `pipe_ctrl_pkg` holds the FSM state enum (IDLE/BUSY/DONE), the counter-width default, and the wait-count width `$clog2(16)`.
- Sub-module `sram_wait_fsm` holds the FSM, the count-down and the strobes. Its ports are `clk`, `rst`, `mem_r_en`, `mem_w_en`, `mem_stall`, `sram_en` and `sram_we`.
- Hazard logic, priority muxing and counters live in the top level.

## Test plan
- `fwd_en`=0, `id_src1`=3, `exe_dest`=3, `exe_wb_en`=1 → `hazard`, `freeze_pc`, `freeze_if_id`, `flush_id_exe` all 1; `stall_cnt` +1.
- `fwd_en`=1, same match with `exe_mem_r_en`=0 → `hazard`=0. With `exe_mem_r_en`=1 → `hazard`=1. With `id_two_src`=0 and the match only on `id_src2` → `hazard`=0.
- `SRAM_WAIT`=5, one-cycle `mem_r_en` held by a frozen pipe → `mem_stall`=1 for exactly 6 cycles, then 0 for one DONE cycle; `sram_we`=0 throughout.
- `exe_branch_taken`=1 during a stall → no flush while `mem_stall`=1; `flush_if_id` = `flush_id_exe` = 1 on the DONE cycle; `flush_cnt`=1.
- `rst` pulsed in the 3rd BUSY cycle → all outputs 0 during reset, IDLE afterwards, counters = 0.
- `CNT_W`=4 with a hazard held for 20 cycles → `stall_cnt` saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline controller and its SRAM wait-state FSM.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    localparam int CNT_W_DEF = 16;
    localparam int WAIT_W    = $clog2(16);
endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-status inputs and control outputs of the pipeline controller.
interface pipe_ctrl_if #(parameter int CNT_W = pipe_ctrl_pkg::CNT_W_DEF);
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic [3:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             fwd_en;
    logic             exe_branch_taken;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             hazard;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             flush_if_id;
    logic             flush_id_exe;
    logic             mem_stall;
    logic             sram_en;
    logic             sram_we;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // master: the pipeline stages; slave: the controller
    modport master (
        output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, fwd_en, exe_branch_taken, mem_r_en, mem_w_en,
        input  hazard, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe,
               mem_stall, sram_en, sram_we, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, fwd_en, exe_branch_taken, mem_r_en, mem_w_en,
        output hazard, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe,
               mem_stall, sram_en, sram_we, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sram_wait_fsm.sv
// Wait-state sequencer: holds the pipe while a load/store owns the multicycle SRAM,
// then releases for one DONE cycle so the same instruction cannot re-trigger.
module sram_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_r_en,
    input  logic mem_w_en,
    output logic mem_stall,
    output logic sram_en,
    output logic sram_we
);
    mem_state_t        state, nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;
    logic              we_q, we_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            we_q  <= we_nxt;
        end
    end

    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt;
        we_nxt    = we_q;
        mem_stall = 1'b0;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        case (state)
            IDLE: if (mem_r_en || mem_w_en) begin
                mem_stall = 1'b1;
                sram_en   = 1'b1;
                sram_we   = mem_w_en;
                we_nxt    = mem_w_en;
                cnt_nxt   = WAIT_W'(SRAM_WAIT - 1);
                nxt       = BUSY;
            end
            BUSY: begin
                mem_stall = 1'b1;
                sram_en   = 1'b1;
                sram_we   = we_q;
                if (cnt == '0) nxt = DONE;
                else           cnt_nxt = cnt - 1'b1;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (rst) begin
            mem_stall = 1'b0;
            sram_en   = 1'b0;
            sram_we   = 1'b0;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: RAW hazard detection, branch flush / freeze priority,
// SRAM wait-state stall and saturating bring-up counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT = 5,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    logic             stall;
    logic             m1, m2, n1, n2, haz_raw, haz, br, hz_frz;
    logic [CNT_W-1:0] stall_q, flush_q;

    sram_wait_fsm #(.SRAM_WAIT(SRAM_WAIT)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (bus.mem_r_en),
        .mem_w_en  (bus.mem_w_en),
        .mem_stall (stall),
        .sram_en   (bus.sram_en),
        .sram_we   (bus.sram_we)
    );

    always_comb begin
        m1 = bus.exe_wb_en & (bus.exe_dest == bus.id_src1);
        m2 = bus.exe_wb_en & bus.id_two_src & (bus.exe_dest == bus.id_src2);
        n1 = bus.mem_wb_en & (bus.mem_dest == bus.id_src1);
        n2 = bus.mem_wb_en & bus.id_two_src & (bus.mem_dest == bus.id_src2);
        // with forwarding only a load in EXE cannot be bypassed in time
        haz_raw = bus.fwd_en ? ((m1 | m2) & bus.exe_mem_r_en) : (m1 | m2 | n1 | n2);
        haz     = haz_raw & ~rst;
        br      = bus.exe_branch_taken & ~stall & ~rst;
        hz_frz  = haz & ~stall & ~bus.exe_branch_taken;
    end

    always_comb begin
        bus.hazard       = haz;
        bus.freeze_pc    = hz_frz;
        bus.freeze_if_id = hz_frz;
        bus.flush_if_id  = br;
        bus.flush_id_exe = br | hz_frz;
        bus.mem_stall    = stall;
        bus.stall_cnt    = rst ? '0 : stall_q;
        bus.flush_cnt    = rst ? '0 : flush_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((stall | haz) && !(&stall_q)) stall_q <= stall_q + 1'b1;
            if (br && !(&flush_q))            flush_q <= flush_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (SRAM_WAIT=5/CNT_W=16 and SRAM_WAIT=2/CNT_W=4)
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en;
    logic       exe_branch_taken, mem_r_en, mem_w_en;

    int checks = 0;
    int passed = 0;

    pipe_ctrl_if #(.CNT_W(16)) bus_a ();
    pipe_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_a.id_src1 = id_src1;           assign bus_b.id_src1 = id_src1;
    assign bus_a.id_src2 = id_src2;           assign bus_b.id_src2 = id_src2;
    assign bus_a.id_two_src = id_two_src;     assign bus_b.id_two_src = id_two_src;
    assign bus_a.exe_dest = exe_dest;         assign bus_b.exe_dest = exe_dest;
    assign bus_a.exe_wb_en = exe_wb_en;       assign bus_b.exe_wb_en = exe_wb_en;
    assign bus_a.exe_mem_r_en = exe_mem_r_en; assign bus_b.exe_mem_r_en = exe_mem_r_en;
    assign bus_a.mem_dest = mem_dest;         assign bus_b.mem_dest = mem_dest;
    assign bus_a.mem_wb_en = mem_wb_en;       assign bus_b.mem_wb_en = mem_wb_en;
    assign bus_a.fwd_en = fwd_en;             assign bus_b.fwd_en = fwd_en;
    assign bus_a.exe_branch_taken = exe_branch_taken;
    assign bus_b.exe_branch_taken = exe_branch_taken;
    assign bus_a.mem_r_en = mem_r_en;         assign bus_b.mem_r_en = mem_r_en;
    assign bus_a.mem_w_en = mem_w_en;         assign bus_b.mem_w_en = mem_w_en;

    pipe_ctrl #(.SRAM_WAIT(5), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pipe_ctrl #(.SRAM_WAIT(2), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // model state: stall cycles still owed after the current one, release cycle, latched write
    int busy_rem[2];
    bit done_m[2];
    bit we_lat[2];
    int scnt[2];
    int fcnt[2];
    bit smp_stall_a, smp_we_a;

    function automatic int wt(int d);
        return (d == 0) ? 5 : 2;
    endfunction

    function automatic int cmax(int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    function automatic bit raw_haz();
        bit exe_hit, mem_hit;
        exe_hit = exe_wb_en && (exe_dest == id_src1 || (id_two_src && exe_dest == id_src2));
        mem_hit = mem_wb_en && (mem_dest == id_src1 || (id_two_src && mem_dest == id_src2));
        if (fwd_en) return exe_hit && exe_mem_r_en;
        return exe_hit || mem_hit;
    endfunction

    function automatic bit m_stall(int d);
        if (rst) return 1'b0;
        if (busy_rem[d] > 0) return 1'b1;
        if (done_m[d]) return 1'b0;
        return mem_r_en || mem_w_en;
    endfunction

    function automatic bit m_we(int d);
        if (rst) return 1'b0;
        if (busy_rem[d] > 0) return we_lat[d];
        if (done_m[d]) return 1'b0;
        return mem_w_en;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_dut(input int d, input logic hz, input logic fpc, input logic fif,
                           input logic flif, input logic flide, input logic ms,
                           input logic en, input logic we, input int sc, input int fc);
        bit st, h, br, frz;
        st  = m_stall(d);
        h   = !rst && raw_haz();
        br  = !rst && exe_branch_taken && !st;
        frz = h && !st && !exe_branch_taken;
        chk($sformatf("d%0d hazard", d), int'(hz), int'(h));
        chk($sformatf("d%0d freeze_pc", d), int'(fpc), int'(frz));
        chk($sformatf("d%0d freeze_if_id", d), int'(fif), int'(frz));
        chk($sformatf("d%0d flush_if_id", d), int'(flif), int'(br));
        chk($sformatf("d%0d flush_id_exe", d), int'(flide), int'(br || frz));
        chk($sformatf("d%0d mem_stall", d), int'(ms), int'(st));
        chk($sformatf("d%0d sram_en", d), int'(en), int'(st));
        chk($sformatf("d%0d sram_we", d), int'(we), int'(m_we(d)));
        chk($sformatf("d%0d stall_cnt", d), sc, rst ? 0 : scnt[d]);
        chk($sformatf("d%0d flush_cnt", d), fc, rst ? 0 : fcnt[d]);
    endtask

    task automatic update();
        for (int d = 0; d < 2; d++) begin
            bit st, h;
            st = m_stall(d);
            h  = !rst && raw_haz();
            if (rst) begin
                busy_rem[d] = 0; done_m[d] = 0; we_lat[d] = 0; scnt[d] = 0; fcnt[d] = 0;
            end else begin
                if ((st || h) && scnt[d] < cmax(d)) scnt[d]++;
                if (exe_branch_taken && !st && fcnt[d] < cmax(d)) fcnt[d]++;
                if (busy_rem[d] > 0) begin
                    busy_rem[d]--;
                    if (busy_rem[d] == 0) done_m[d] = 1;
                end else if (done_m[d]) begin
                    done_m[d] = 0;
                end else if (mem_r_en || mem_w_en) begin
                    busy_rem[d] = wt(d);
                    we_lat[d]   = mem_w_en;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        smp_stall_a = bus_a.mem_stall;
        smp_we_a    = bus_a.sram_we;
        cmp_dut(0, bus_a.hazard, bus_a.freeze_pc, bus_a.freeze_if_id, bus_a.flush_if_id,
                bus_a.flush_id_exe, bus_a.mem_stall, bus_a.sram_en, bus_a.sram_we,
                int'(bus_a.stall_cnt), int'(bus_a.flush_cnt));
        cmp_dut(1, bus_b.hazard, bus_b.freeze_pc, bus_b.freeze_if_id, bus_b.flush_if_id,
                bus_b.flush_id_exe, bus_b.mem_stall, bus_b.sram_en, bus_b.sram_we,
                int'(bus_b.stall_cnt), int'(bus_b.flush_cnt));
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic clear_in();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; exe_dest = 4'd0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = 4'd0; mem_wb_en = 1'b0;
        fwd_en = 1'b0; exe_branch_taken = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    initial begin
        int n_stall, n_we;
        rst = 1'b1;
        clear_in();
        for (int i = 0; i < 2; i++) tick();
        rst = 1'b0;
        #1;
        chk("reset stall_cnt", int'(bus_a.stall_cnt), 0);
        chk("reset mem_stall", int'(bus_a.mem_stall), 0);
        tick();

        // EXE-stage RAW without forwarding
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        chk("raw hazard", int'(bus_a.hazard), 1);
        chk("raw freeze_pc", int'(bus_a.freeze_pc), 1);
        chk("raw freeze_if_id", int'(bus_a.freeze_if_id), 1);
        chk("raw flush_id_exe", int'(bus_a.flush_id_exe), 1);
        tick();
        chk("raw stall_cnt", int'(bus_a.stall_cnt), 1);

        fwd_en = 1'b1;
        #1 chk("fwd no load", int'(bus_a.hazard), 0);
        tick();
        exe_mem_r_en = 1'b1;
        #1 chk("fwd load-use", int'(bus_a.hazard), 1);
        tick();
        id_src1 = 4'd1; id_src2 = 4'd3; id_two_src = 1'b0;
        #1 chk("src2 unused", int'(bus_a.hazard), 0);
        tick();
        id_two_src = 1'b1;
        #1 chk("src2 load-use", int'(bus_a.hazard), 1);
        tick();
        clear_in();
        id_src1 = 4'd15; mem_dest = 4'd15; mem_wb_en = 1'b1;
        #1 chk("mem r15 hazard", int'(bus_a.hazard), 1);
        tick();

        // load held by the frozen pipe through stall and release
        clear_in();
        mem_r_en = 1'b1;
        n_stall = 0; n_we = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_stall += int'(smp_stall_a);
            n_we    += int'(smp_we_a);
        end
        chk("load stall cycles", n_stall, 6);
        chk("load sram_we", n_we, 0);
        chk("load done cycle", int'(smp_stall_a), 0);
        mem_r_en = 1'b0;
        tick();

        // store with a taken branch waiting behind the stall
        mem_w_en = 1'b1; exe_branch_taken = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("branch flush_cnt a", int'(bus_a.flush_cnt), 1);
        chk("branch flush_cnt b", int'(bus_b.flush_cnt), 1);
        clear_in();
        tick();
        tick();

        // reset in the third BUSY cycle
        mem_r_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        #1;
        chk("rst mem_stall", int'(bus_a.mem_stall), 0);
        chk("rst sram_en", int'(bus_a.sram_en), 0);
        chk("rst stall_cnt", int'(bus_a.stall_cnt), 0);
        tick();
        rst = 1'b0; mem_r_en = 1'b0;
        #1;
        chk("post rst mem_stall", int'(bus_a.mem_stall), 0);
        chk("post rst stall_cnt", int'(bus_a.stall_cnt), 0);
        chk("post rst flush_cnt", int'(bus_a.flush_cnt), 0);
        tick();

        // held hazard saturates the narrow counter
        id_src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat stall_cnt b", int'(bus_b.stall_cnt), 15);
        chk("stall_cnt a", int'(bus_a.stall_cnt), 20);
        clear_in();
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
